fpga_ram_arbiter: RTL and testbench
===================================

Name: fpga_ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port FPGA block-RAM/ROM macro.
- The macro has a 32-bit word, byte-lane write enables and a synchronous read with 1-cycle latency.
- Lets an instruction-fetch port (M0) and a data/loader port (M1) share one memory instance.
- Policy: round-robin with a bounded burst counter; registered read-return qualification per requester.

Parameters:
- AW, 16, byte-address width; word address is [AW-1:2].
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.

Ports:
- CLK  input  1  system clock
- RESETn  input  1  asynchronous active-low reset
- M0_REQ  input  1  requester 0 access request; held until M0_GNT
- M0_ADDR  input  AW-2  requester 0 word address
- M0_WDATA  input  32  requester 0 write data
- M0_WREN  input  4  requester 0 byte write enables; 4'b0000 = read
- M0_GNT  output  1  access accepted this cycle (combinational)
- M0_RVALID  output  1  read data valid for requester 0
- M0_RDATA  output  32  read data to requester 0
- M1_REQ, M1_ADDR, M1_WDATA, M1_WREN, M1_GNT, M1_RVALID, M1_RDATA: same as M0_*, for requester 1
- MEM_CS  output  1  memory select
- MEM_ADDR  output  AW-2  memory word address
- MEM_WDATA  output  32  memory write data
- MEM_WREN  output  4  memory byte write enables
- MEM_RDATA  input  32  memory read data (valid 1 cycle after a read access)

Behaviour:
- Only one clock (CLK). Reset is asynchronous and active-low (RESETn). All state clears on RESETn low, independent of CLK.
- State:
  - owner: 1 bit, last granted requester; reset 0.
  - burst_cnt: 4 bits; reset 0.
  - rv0, rv1: read-valid flops; reset 0.
- Grant (combinational, same cycle as request):
  - Neither REQ: no grant.
  - One REQ: grant that requester.
  - Both REQ: grant owner if burst_cnt < MAX_BURST, else grant the other requester.
- Counter update on the clock edge:
  - Grant to owner: burst_cnt increments, saturating at 15.
  - Grant to the non-owner: owner <= granted requester, burst_cnt <= 1.
  - Cycle with no grant: burst_cnt <= 0; owner unchanged.
- Memory mux:
  - A granted cycle drives MEM_CS=1 and MEM_ADDR/MEM_WDATA/MEM_WREN from the granted requester.
  - An idle cycle drives MEM_CS=0, MEM_ADDR=0, MEM_WDATA=0, MEM_WREN=0.
- Read return:
  - rvN <= MN_GNT & (MN_WREN==4'b0000).
  - MN_RVALID = rvN.
  - MN_RDATA = rvN ? MEM_RDATA : 32'h0.
  - Read latency is 1 cycle after grant.
  - Back-to-back reads by either requester are legal, one per cycle.
- Writes:
  - Complete at the grant edge; no RVALID.
  - Partial byte writes pass MEM_WREN unchanged.
- Requester rules:
  - Must hold REQ/ADDR/WDATA/WREN stable until GNT.
  - May drop REQ the cycle after GNT or keep it high for the next access.
- Simultaneous read grant and return: the RVALID for access N coincides with the GNT of access N+1; both are legal.
- Reset mid-operation: a pending rvN is discarded; no RVALID after RESETn deasserts until a new grant.
- Reset values of outputs:
  - GNTs 0 while REQs are low.
  - RVALIDs 0, RDATAs 0.
  - MEM_CS 0; MEM_* buses 0.

Optional Feature:
- Macro: FPGA_RAM_ARB_FIXED_PRI_EN.
- Defined: fixed priority.
  - M0 always wins when M0_REQ=1; M1 is granted only when M0_REQ=0.
  - owner/burst_cnt logic is not built; MAX_BURST is ignored.
- Undefined: round-robin with burst limit as in Behaviour.

Test Plan:
- Single read: reset; M0 reads ADDR=14'h0010, memory holds 32'hDEADBEEF → M0_GNT=1 in the request cycle, MEM_CS=1, M0_RVALID=1 next cycle with M0_RDATA=32'hDEADBEEF; M1_RVALID stays 0.
- Byte write then read: M1 writes WREN=4'b0100, WDATA=32'h00AB0000 to ADDR 5, then reads ADDR 5 → MEM_WREN=4'b0100 in the write cycle; read returns byte[23:16]=8'hAB with the other bytes unchanged.
- Burst limit (MAX_BURST=4): both REQ held high continuously from reset → grant sequence M0,M0,M0,M0,M1,M1,M1,M1,M0,…; each RVALID appears 1 cycle after its GNT.
- Idle resets burst: M0 takes 3 grants, 1 idle cycle, then both request → M0 gets 4 more grants before M1.
- Reset mid-read: assert RESETn low in the cycle after an M1 read grant → M1_RVALID=0, MEM_CS=0; after release the first contended grant goes to M0.
- FIXED_PRI_EN defined: both REQ high for 10 cycles → M0_GNT=1 all 10 cycles, M1_GNT=0; M1 is granted in the first cycle M0_REQ=0.

Source files
------------

// File: rtl/fpga_ram_arbiter.sv
// Two-requester arbiter/sequencer for a single-port FPGA block RAM with 1-cycle read latency.
// Define FPGA_RAM_ARB_FIXED_PRI_EN for fixed M0-over-M1 priority instead of round-robin with burst limit.
module fpga_ram_arbiter #(
    parameter int AW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          M0_REQ,
    input  logic [AW-3:0] M0_ADDR,
    input  logic [31:0]   M0_WDATA,
    input  logic [3:0]    M0_WREN,
    output logic          M0_GNT,
    output logic          M0_RVALID,
    output logic [31:0]   M0_RDATA,
    input  logic          M1_REQ,
    input  logic [AW-3:0] M1_ADDR,
    input  logic [31:0]   M1_WDATA,
    input  logic [3:0]    M1_WREN,
    output logic          M1_GNT,
    output logic          M1_RVALID,
    output logic [31:0]   M1_RDATA,
    output logic          MEM_CS,
    output logic [AW-3:0] MEM_ADDR,
    output logic [31:0]   MEM_WDATA,
    output logic [3:0]    MEM_WREN,
    input  logic [31:0]   MEM_RDATA
);

    logic gnt0;
    logic gnt1;
    logic rv0;
    logic rv1;

`ifdef FPGA_RAM_ARB_FIXED_PRI_EN
    always_comb begin
        gnt0 = M0_REQ;
        gnt1 = M1_REQ & ~M0_REQ;
    end
`else
    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    logic       owner;
    logic [3:0] burst_cnt;
    logic       pick;

    // On contention the current owner keeps the port until its burst budget is used up.
    always_comb begin
        pick = (burst_cnt < MAXB) ? owner : ~owner;
        gnt0 = M0_REQ & (~M1_REQ | ~pick);
        gnt1 = M1_REQ & (~M0_REQ | pick);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            owner     <= 1'b0;
            burst_cnt <= '0;
        end else if (!(gnt0 | gnt1)) begin
            burst_cnt <= '0;
        end else if (gnt1 == owner) begin
            if (burst_cnt != 4'hF)
                burst_cnt <= burst_cnt + 4'd1;
        end else begin
            owner     <= gnt1;
            burst_cnt <= 4'd1;
        end
    end
`endif

    always_comb begin
        MEM_CS    = gnt0 | gnt1;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_WREN  = '0;
        if (gnt0) begin
            MEM_ADDR  = M0_ADDR;
            MEM_WDATA = M0_WDATA;
            MEM_WREN  = M0_WREN;
        end else if (gnt1) begin
            MEM_ADDR  = M1_ADDR;
            MEM_WDATA = M1_WDATA;
            MEM_WREN  = M1_WREN;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= gnt0 & (M0_WREN == 4'b0000);
            rv1 <= gnt1 & (M1_WREN == 4'b0000);
        end
    end

    assign M0_GNT    = gnt0;
    assign M1_GNT    = gnt1;
    assign M0_RVALID = rv0;
    assign M1_RVALID = rv1;
    assign M0_RDATA  = rv0 ? MEM_RDATA : '0;
    assign M1_RDATA  = rv1 ? MEM_RDATA : '0;

endmodule

// File: tb/tb_fpga_ram_arbiter.sv
// Directed bench for fpga_ram_arbiter with a behavioural byte-lane block RAM attached.
module tb_fpga_ram_arbiter;

    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          M0_REQ, M1_REQ;
    logic [AW-3:0] M0_ADDR, M1_ADDR;
    logic [31:0]   M0_WDATA, M1_WDATA;
    logic [3:0]    M0_WREN, M1_WREN;
    logic          M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
    logic [31:0]   M0_RDATA, M1_RDATA;
    logic          MEM_CS;
    logic [AW-3:0] MEM_ADDR;
    logic [31:0]   MEM_WDATA;
    logic [3:0]    MEM_WREN;
    logic [31:0]   MEM_RDATA;

    logic [31:0] mem [0:63];
    logic        preload;

    int vectors = 0;
    int miscompares = 0;

    fpga_ram_arbiter #(.AW(AW), .MAX_BURST(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_WREN(M0_WREN),
        .M0_GNT(M0_GNT), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_WREN(M1_WREN),
        .M1_GNT(M1_GNT), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
        .MEM_CS(MEM_CS), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WREN(MEM_WREN),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAM, byte-lane writes, 64 words.
    always @(posedge CLK) begin
        if (preload) begin
            mem[16] <= 32'hDEADBEEF;
            mem[5]  <= 32'h11223344;
        end else if (MEM_CS) begin
            if (MEM_WREN == 4'b0000)
                MEM_RDATA <= mem[MEM_ADDR[5:0]];
            for (int unsigned b = 0; b < 4; b++)
                if (MEM_WREN[b])
                    mem[MEM_ADDR[5:0]][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_reqs();
        M0_REQ = 1'b0; M1_REQ = 1'b0;
        M0_WREN = 4'b0000; M1_WREN = 4'b0000;
        M0_WDATA = '0; M1_WDATA = '0;
        M0_ADDR = '0; M1_ADDR = '0;
    endtask

    task automatic do_reset();
        idle_reqs();
        RESETn = 1'b0;
        repeat (2) tick();
        RESETn = 1'b1;
        tick();
    endtask

    initial begin
        preload = 1'b1;
        idle_reqs();
        RESETn = 1'b0;
        #2;
        chk("rst_m0_gnt", 32'(M0_GNT), 32'h0);
        chk("rst_m1_gnt", 32'(M1_GNT), 32'h0);
        chk("rst_m0_rvalid", 32'(M0_RVALID), 32'h0);
        chk("rst_m1_rvalid", 32'(M1_RVALID), 32'h0);
        chk("rst_m0_rdata", M0_RDATA, 32'h0);
        chk("rst_mem_cs", 32'(MEM_CS), 32'h0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 32'h0);
        chk("rst_mem_wren", 32'(MEM_WREN), 32'h0);
        repeat (2) tick();
        preload = 1'b0;
        RESETn = 1'b1;
        tick();

        // Single read by M0
        M0_REQ = 1'b1; M0_ADDR = 14'h0010;
        #1;
        chk("rd_m0_gnt", 32'(M0_GNT), 32'h1);
        chk("rd_m1_gnt", 32'(M1_GNT), 32'h0);
        chk("rd_mem_cs", 32'(MEM_CS), 32'h1);
        chk("rd_mem_addr", 32'(MEM_ADDR), 32'h10);
        tick();
        M0_REQ = 1'b0;
        #1;
        chk("rd_m0_rvalid", 32'(M0_RVALID), 32'h1);
        chk("rd_m0_rdata", M0_RDATA, 32'hDEADBEEF);
        chk("rd_m1_rvalid", 32'(M1_RVALID), 32'h0);
        chk("idle_mem_cs", 32'(MEM_CS), 32'h0);
        tick();
        chk("rd_m0_rvalid_drop", 32'(M0_RVALID), 32'h0);

        // Byte write then read by M1
        M1_REQ = 1'b1; M1_ADDR = 14'd5; M1_WREN = 4'b0100; M1_WDATA = 32'h00AB0000;
        #1;
        chk("wr_m1_gnt", 32'(M1_GNT), 32'h1);
        chk("wr_mem_wren", 32'(MEM_WREN), 32'h4);
        chk("wr_mem_wdata", MEM_WDATA, 32'h00AB0000);
        chk("wr_mem_addr", 32'(MEM_ADDR), 32'h5);
        tick();
        M1_WREN = 4'b0000; M1_WDATA = '0;
        #1;
        chk("wr_no_rvalid", 32'(M1_RVALID), 32'h0);
        chk("rb_m1_gnt", 32'(M1_GNT), 32'h1);
        chk("rb_mem_wren", 32'(MEM_WREN), 32'h0);
        tick();
        M1_REQ = 1'b0;
        #1;
        chk("rb_m1_rvalid", 32'(M1_RVALID), 32'h1);
        chk("rb_m1_rdata", M1_RDATA, 32'h11AB3344);
        chk("rb_m0_rvalid", 32'(M0_RVALID), 32'h0);
        chk("rb_m0_rdata", M0_RDATA, 32'h0);
        tick();

`ifndef FPGA_RAM_ARB_FIXED_PRI_EN
        // Burst limit: both requesting continuously from reset
        do_reset();
        M0_REQ = 1'b1; M0_ADDR = 14'h0010;
        M1_REQ = 1'b1; M1_ADDR = 14'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("bl_m0_gnt%0d", i), 32'(M0_GNT), 32'((i < 4) || (i >= 8)));
            chk($sformatf("bl_m1_gnt%0d", i), 32'(M1_GNT), 32'((i >= 4) && (i < 8)));
            chk($sformatf("bl_m0_rv%0d", i), 32'(M0_RVALID), 32'((i >= 1 && i <= 4) || i == 9));
            chk($sformatf("bl_m1_rv%0d", i), 32'(M1_RVALID), 32'(i >= 5 && i <= 8));
            if (i == 3) chk("bl_m0_rdata", M0_RDATA, 32'hDEADBEEF);
            if (i == 6) chk("bl_m1_rdata", M1_RDATA, 32'h11AB3344);
            tick();
        end

        // Idle cycle clears the burst count
        M1_REQ = 1'b0;
        repeat (3) tick();
        M0_REQ = 1'b0;
        tick();
        M0_REQ = 1'b1; M1_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("ib_m0_gnt%0d", i), 32'(M0_GNT), 32'(i < 4));
            chk($sformatf("ib_m1_gnt%0d", i), 32'(M1_GNT), 32'(i == 4));
            tick();
        end
`else
        // Fixed priority: M0 always wins
        do_reset();
        M0_REQ = 1'b1; M0_ADDR = 14'h0010;
        M1_REQ = 1'b1; M1_ADDR = 14'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("fp_m0_gnt%0d", i), 32'(M0_GNT), 32'h1);
            chk($sformatf("fp_m1_gnt%0d", i), 32'(M1_GNT), 32'h0);
            tick();
        end
        M0_REQ = 1'b0;
        #1;
        chk("fp_m1_gnt_free", 32'(M1_GNT), 32'h1);
        tick();
`endif

        // Reset in the cycle after an M1 read grant
        idle_reqs();
        tick();
        M1_REQ = 1'b1; M1_ADDR = 14'd5;
        #1;
        chk("mr_m1_gnt", 32'(M1_GNT), 32'h1);
        tick();
        M1_REQ = 1'b0;
        RESETn = 1'b0;
        #1;
        chk("mr_m1_rvalid", 32'(M1_RVALID), 32'h0);
        chk("mr_m1_rdata", M1_RDATA, 32'h0);
        chk("mr_mem_cs", 32'(MEM_CS), 32'h0);
        tick();
        RESETn = 1'b1;
        tick();
        chk("mr_post_rvalid", 32'(M1_RVALID), 32'h0);
        M0_REQ = 1'b1; M0_ADDR = 14'h0010;
        M1_REQ = 1'b1; M1_ADDR = 14'd5;
        #1;
        chk("mr_first_m0", 32'(M0_GNT), 32'h1);
        chk("mr_first_m1", 32'(M1_GNT), 32'h0);
        tick();
        idle_reqs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
